if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 11 +
 rtl/if_stage.sv | 135 +++++++++++++
 2 files changed

// File: rtl/if_stage_pkg.sv
// Shared pipeline types for the fetch stage: FSM state encoding and PC step.
package if_stage_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HELD  = 1'b1
    } if_state_e;

    localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, one-deep skid buffer and IF/ID register.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
//
// state | meaning
// FETCH | request outstanding to imem, imemREN=1
// HELD  | word parked in skid buffer while decode stalls, imemREN=0
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] next_pc,
    input  logic        redirect,
    input  logic        stall,
    output logic [31:0] imemaddr,
    output logic        imemREN,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic [31:0] pc_plus4,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pcplus4,
    output logic        ifid_valid
`ifdef IF_PERF_CNT_EN
   ,output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    if_state_e   state_q;
    logic [31:0] pc_q;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pcplus4_q;
    logic [31:0] ifid_instr_q;
    logic [31:0] ifid_pcplus4_q;
    logic        ifid_valid_q;

    logic        load_from_mem;
    logic        load_from_skid;
    logic        park_in_skid;
    logic        bubble;

    assign imemaddr = pc_q;
    assign pc_plus4 = pc_q + PC_INCR;
    assign imemREN  = (state_q == FETCH);

    assign ifid_instr   = ifid_instr_q;
    assign ifid_pcplus4 = ifid_pcplus4_q;
    assign ifid_valid   = ifid_valid_q;

    // Redirect outranks every other condition, so each case is gated by it.
    always_comb begin
        load_from_mem  = 1'b0;
        load_from_skid = 1'b0;
        park_in_skid   = 1'b0;
        bubble         = 1'b0;
        if (!redirect) begin
            if (state_q == FETCH) begin
                load_from_mem = ihit && !stall;
                park_in_skid  = ihit && stall;
                bubble        = !ihit && !stall;
            end else begin
                load_from_skid = !stall;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q        <= FETCH;
            pc_q           <= PC_INIT;
            skid_instr_q   <= '0;
            skid_pcplus4_q <= '0;
            ifid_instr_q   <= '0;
            ifid_pcplus4_q <= '0;
            ifid_valid_q   <= 1'b0;
        end else if (redirect) begin
            state_q        <= FETCH;
            pc_q           <= next_pc;
            skid_instr_q   <= '0;
            skid_pcplus4_q <= '0;
            ifid_valid_q   <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (load_from_mem) begin
                        ifid_instr_q   <= imemload;
                        ifid_pcplus4_q <= pc_plus4;
                        ifid_valid_q   <= 1'b1;
                        pc_q           <= next_pc;
                    end else if (park_in_skid) begin
                        skid_instr_q   <= imemload;
                        skid_pcplus4_q <= pc_plus4;
                        state_q        <= HELD;
                    end else if (bubble) begin
                        ifid_valid_q   <= 1'b0;
                    end
                end
                HELD: begin
                    if (load_from_skid) begin
                        ifid_instr_q   <= skid_instr_q;
                        ifid_pcplus4_q <= skid_pcplus4_q;
                        ifid_valid_q   <= 1'b1;
                        pc_q           <= next_pc;
                        state_q        <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        stall_evt;

    assign stall_evt = (imemREN && !ihit) || (state_q == HELD);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (load_from_mem || load_from_skid) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_evt)                       stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
